// File: rtl/demux_1_8_wr_pkg.sv
// demux_1_8_wr_pkg: shared sizes and fill-state encoding for the 1:8 write-side demux.
package demux_1_8_wr_pkg;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/demux_1_8_wr_if.sv
// demux_1_8_wr_if: word stream in, parallel bank out, release handshake from the reader.
interface demux_1_8_wr_if
    import demux_1_8_wr_pkg::*;
#(
    parameter int DW = 8
);

    logic [DW-1:0]       in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DEPTH*DW-1:0] bank_data;
    logic                bank_full;
    logic                bank_release;
    logic [PTR_W-1:0]    wr_ptr;
    logic                release_err;

    modport master (
        output in_data, in_valid, bank_release,
        input  in_ready, bank_data, bank_full, wr_ptr, release_err
    );

    modport slave (
        input  in_data, in_valid, bank_release,
        output in_ready, bank_data, bank_full, wr_ptr, release_err
    );

endinterface

// File: rtl/demux_1_8_wr_bank_reg.sv
// demux_1_8_wr_bank_reg: DEPTH x DW register bank, one addressed write port, flat parallel read-out.
module demux_1_8_wr_bank_reg
    import demux_1_8_wr_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                SYS_CLK,
    input  logic                SYS_NRST,
    input  logic                we_i,
    input  logic [PTR_W-1:0]    addr_i,
    input  logic [DW-1:0]       wdata_i,
    output logic [DEPTH*DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_rd
        assign rdata_o[k*DW +: DW] = mem_q[k];
    end

endmodule

// File: rtl/demux_1_8_wr.sv
// demux_1_8_wr: packs 8 consecutive stream words into a bank presented in parallel to the 8:1 reader.
// Define DEMUX_1_8_PINGPONG_EN for double-buffered A/B banks (write one while the other is read).
module demux_1_8_wr
    import demux_1_8_wr_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          SYS_CLK,
    input  logic          SYS_NRST,
    demux_1_8_wr_if.slave bus
);

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic                release_err_q, release_err_d;
    logic                rdy, full, xfer, slot7;
    logic [DEPTH*DW-1:0] data_a, rd_data;

    assign xfer     = bus.in_valid & rdy;
    assign slot7    = xfer & (wr_ptr_q == LAST_SLOT);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(xfer);

    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            wr_ptr_q      <= '0;
            release_err_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            release_err_q <= release_err_d;
        end
    end

`ifdef DEMUX_1_8_PINGPONG_EN
    logic [1:0]          full_q, full_d;
    logic                wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, rel_ok;
    logic [DEPTH*DW-1:0] data_b;

    // A release only counts against a bank that is actually held full.
    assign rel_ok = bus.bank_release & full_q[rd_bank_q];

    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    always_comb begin
        full_d = full_q;
        if (slot7) full_d[wr_bank_q] = 1'b1;
        if (rel_ok) full_d[rd_bank_q] = 1'b0;
        wr_bank_d     = wr_bank_q ^ slot7;
        rd_bank_d     = rd_bank_q ^ rel_ok;
        release_err_d = release_err_q | (bus.bank_release & ~full_q[rd_bank_q]);
    end

    always_comb begin
        rdy     = ~full_q[wr_bank_q];
        full    = full_q[rd_bank_q];
        rd_data = rd_bank_q ? data_b : data_a;
    end

    demux_1_8_wr_bank_reg #(.DW(DW)) u_bank_b (
        .SYS_CLK (SYS_CLK),
        .SYS_NRST(SYS_NRST),
        .we_i    (xfer & wr_bank_q),
        .addr_i  (wr_ptr_q),
        .wdata_i (bus.in_data),
        .rdata_o (data_b)
    );

    demux_1_8_wr_bank_reg #(.DW(DW)) u_bank_a (
        .SYS_CLK (SYS_CLK),
        .SYS_NRST(SYS_NRST),
        .we_i    (xfer & ~wr_bank_q),
        .addr_i  (wr_ptr_q),
        .wdata_i (bus.in_data),
        .rdata_o (data_a)
    );
`else
    state_t state_q, state_d;

    always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) state_q <= FILL;
        else           state_q <= state_d;
    end

    // A release seen while filling (even alongside the slot-7 write) is an error, not a drain.
    always_comb begin
        state_d       = (state_q == FILL) ? (slot7 ? FULL : FILL) : (bus.bank_release ? FILL : FULL);
        release_err_d = release_err_q | (bus.bank_release & (state_q == FILL));
    end

    always_comb begin
        rdy     = state_q == FILL;
        full    = state_q == FULL;
        rd_data = data_a;
    end

    demux_1_8_wr_bank_reg #(.DW(DW)) u_bank_a (
        .SYS_CLK (SYS_CLK),
        .SYS_NRST(SYS_NRST),
        .we_i    (xfer),
        .addr_i  (wr_ptr_q),
        .wdata_i (bus.in_data),
        .rdata_o (data_a)
    );
`endif

    assign bus.in_ready    = rdy;
    assign bus.bank_full   = full;
    assign bus.bank_data   = rd_data;
    assign bus.wr_ptr      = wr_ptr_q;
    assign bus.release_err = release_err_q;

endmodule

// File: tb/tb_demux_1_8_wr.sv
// tb_demux_1_8_wr: directed + randomised stimulus against a queue-based model; frames checked by a monitor.
module tb_demux_1_8_wr;
    import demux_1_8_wr_pkg::*;

`ifdef DEMUX_1_8_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic SYS_CLK  = 1'b0;
    logic SYS_NRST = 1'b1;

    demux_1_8_wr_if #(.DW(8)) bus ();
    demux_1_8_wr #(.DW(8)) dut (.SYS_CLK(SYS_CLK), .SYS_NRST(SYS_NRST), .bus(bus));

    always #5 SYS_CLK = ~SYS_CLK;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  partial[$];
    logic [63:0] frames[$];
    logic [63:0] exp_q[$];
    bit          m_err, presented;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit v, logic [7:0] d, bit r);
        bus.in_valid     = v;
        bus.in_data      = d;
        bus.bank_release = r;
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_bank_full"}, bus.bank_full, 0);
        check({tag, "_wr_ptr"}, bus.wr_ptr, 0);
        check({tag, "_release_err"}, bus.release_err, 0);
        check({tag, "_bank_data"}, bus.bank_data, 0);
    endtask

    // Model: words accumulate in 'partial'; completed frames wait in 'frames' until released.
    always @(posedge SYS_CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            partial.delete();
            frames.delete();
            exp_q.delete();
            m_err     = 0;
            presented = 0;
        end else begin
            automatic int held = frames.size();
            if (bus.bank_release && held == 0) m_err = 1;
            if (bus.in_valid && held < NB) begin
                partial.push_back(bus.in_data);
                if (partial.size() == DEPTH) begin
                    automatic logic [63:0] f = '0;
                    for (int k = 0; k < DEPTH; k++) f[k*8 +: 8] = partial[k];
                    frames.push_back(f);
                    exp_q.push_back(f);
                    partial.delete();
                end
            end
            if (bus.bank_release && held > 0) begin
                void'(frames.pop_front());
                presented = 0;
            end
        end
    end

    // Monitor: status every cycle, and each newly presented bank popped from the scoreboard.
    always @(negedge SYS_CLK) begin
        if (SYS_NRST) begin
            check("in_ready", bus.in_ready, frames.size() < NB);
            check("bank_full", bus.bank_full, frames.size() > 0);
            check("wr_ptr", bus.wr_ptr, partial.size());
            check("release_err", bus.release_err, m_err);
            if (frames.size() == 0)
                for (int k = 0; k < partial.size(); k++)
                    check("fill_slot", bus.bank_data[k*8 +: 8], partial[k]);
            if (bus.bank_full && !presented) begin
                presented = 1;
                check("frame_queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("frame_data", bus.bank_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.in_valid     = 0;
        bus.in_data      = 0;
        bus.bank_release = 0;
        #2 SYS_NRST = 0;
        repeat (3) @(posedge SYS_CLK);
        #1;
        check_reset_values("reset");
        SYS_NRST = 1;

`ifdef DEMUX_1_8_PINGPONG_EN
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(8'h20 + i), i == 15);
            check("pp_in_ready", bus.in_ready, 1);
        end
        check("pp_bank_full", bus.bank_full, 1);
        check("pp_bank_b", bus.bank_data, 64'h2F2E2D2C2B2A2928);
        step(0, 0, 1);
        step(0, 0, 0);
        check("pp_drained", bus.bank_full, 0);
`else
        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0);
        check("fill_full", bus.bank_full, 1);
        check("fill_data", bus.bank_data, 64'h1716151413121110);
        check("fill_ready", bus.in_ready, 0);
        check("fill_ptr", bus.wr_ptr, 0);

        for (int i = 0; i < 5; i++) step(1, 8'hAA, 0);
        check("hold_data", bus.bank_data, 64'h1716151413121110);
        check("hold_ptr", bus.wr_ptr, 0);
        step(1, 8'hAA, 1);
        check("rel_ready", bus.in_ready, 1);
        check("rel_full", bus.bank_full, 0);
        step(1, 8'hAA, 0);
        check("rel_slot0", bus.bank_data[7:0], 8'hAA);
        check("rel_ptr", bus.wr_ptr, 1);

        step(1, 8'h31, 0);
        step(1, 8'h32, 0);
        step(0, 0, 1);
        check("err_mid", bus.release_err, 1);
        check("err_mid_ptr", bus.wr_ptr, 3);
        for (int i = 3; i < 7; i++) step(1, 8'(8'h30 + i), 0);
        step(1, 8'h37, 1);
        check("err_s7_full", bus.bank_full, 1);
        check("err_s7_sticky", bus.release_err, 1);
        check("err_s7_data", bus.bank_data, 64'h37363534333231AA);
        step(0, 0, 1);
        check("err_drain", bus.bank_full, 0);

        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0);
        check("mid_ptr", bus.wr_ptr, 5);
`endif
        bus.in_valid     = 0;
        bus.bank_release = 0;
        SYS_NRST = 0;
        #1;
        check_reset_values("async_reset");
        @(posedge SYS_CLK);
        #1;
        SYS_NRST = 1;

        for (int n = 0; n < 1500; n++) begin
            automatic bit v = $urandom_range(0, 99) < 70;
            automatic bit r = (frames.size() > 0) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 199) == 0);
            step(v, 8'($urandom), r);
        end
        for (int n = 0; n < 4 && frames.size() > 0; n++) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        check("frames_unseen", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
